// File: rtl/sweep_pkg.sv
// Shared types and constants for the logic sweep driver.
// Optional comparator feature of the top is selected by the SWEEP_COMPARE_EN macro.
package sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 32;
  localparam int VEC_W       = 6;
  localparam int D_W         = 3;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/sweep_hold_counter.sv
// Hold-time counter: counts 0..HOLD_CYCLES-1 while enabled and strobes last_o
// on the final count, wrapping back to zero.
module sweep_hold_counter #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last_o
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign last_o = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/logic_sweep_driver.sv
// Sweeps all 32 {D,B,A} vectors into the logic unit and captures OUT into a truth table.
// Define SWEEP_COMPARE_EN to add the golden-table comparator (pass_o / err_cnt_o).
//
// state   | meaning
// S_IDLE  | waiting for start; outputs parked at 0
// S_DRIVE | vector vec on {d_o,b_o,a_o}, sampled when the hold counter expires
// S_DONE  | one-cycle done pulse, table_valid raised
module logic_sweep_driver
  import sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 20
`ifdef SWEEP_COMPARE_EN
  ,
  parameter logic [31:0] EXPECTED = 32'h0000_0000
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           a_o,
  output logic           b_o,
  output logic [D_W-1:0] d_o,
  input  logic           out_i,
  output logic           busy,
  output logic           done,
  output logic [31:0]    table_o,
  output logic           table_valid
`ifdef SWEEP_COMPARE_EN
  ,
  output logic           pass_o,
  output logic [5:0]     err_cnt_o
`endif
);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] vec_nxt;
  logic             hold_last;
  logic             sample;
  logic             accept;

  assign vec_nxt = vec + VEC_W'(1);
  assign sample  = (state == S_DRIVE) && hold_last;
  assign accept  = (state == S_IDLE) && start;

  sweep_hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != S_DRIVE),
    .en     (state == S_DRIVE),
    .last_o (hold_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      vec         <= '0;
      a_o         <= 1'b0;
      b_o         <= 1'b0;
      d_o         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_o     <= '0;
      table_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state             <= S_DRIVE;
            vec               <= '0;
            {d_o, b_o, a_o}   <= '0;
            busy              <= 1'b1;
            table_o           <= '0;
            table_valid       <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (hold_last) begin
            table_o[vec[4:0]] <= out_i;
            if (vec == LAST_VEC) begin
              state           <= S_DONE;
              busy            <= 1'b0;
              done            <= 1'b1;
              table_valid     <= 1'b1;
              {d_o, b_o, a_o} <= '0;
            end else begin
              // Next vector goes out on the same edge that samples the current one.
              vec             <= vec_nxt;
              {d_o, b_o, a_o} <= vec_nxt[D_W+1:0];
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SWEEP_COMPARE_EN
  logic       miss;
  logic [5:0] err_nxt;

  assign miss = (out_i != EXPECTED[vec[4:0]]);

  always_comb begin
    err_nxt = err_cnt_o;
    if (sample && miss && (err_cnt_o != 6'd32)) begin
      err_nxt = err_cnt_o + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_o <= '0;
      pass_o    <= 1'b0;
    end else if (accept) begin
      err_cnt_o <= '0;
      pass_o    <= 1'b0;
    end else begin
      err_cnt_o <= err_nxt;
      // Uses err_nxt so a miss on the final vector is reflected in pass_o.
      if (sample && (vec == LAST_VEC)) begin
        pass_o <= (err_nxt == 6'd0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_logic_sweep_driver.sv
// Scoreboard bench for logic_sweep_driver: two instances (HOLD_CYCLES 20 and 1) driving
// a behavioural logic-unit stub; expectations are queued at start and checked on done.
module tb_logic_sweep_driver;

  typedef struct {
    logic [31:0] tbl;
    int          dcyc;
    logic [5:0]  err;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start20, start1;
  logic        a20, b20, a1, b1;
  logic [2:0]  d20, d1;
  logic        out20, out1;
  logic        busy20, done20, tv20, busy1, done1, tv1;
  logic [31:0] tbl20, tbl1;
  logic [5:0]  err20, err1;
  logic        pass20, pass1;

  int mode;
  int cyc;
  int n_vec, n_err;
  exp_t q20[$];
  exp_t q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic stub(input int m, input logic a, input logic b, input logic [2:0] d);
    logic [4:0] idx;
    idx = {d, b, a};
    case (m)
      0:       return a & b;
      1:       return d[0] ? (a ^ b) : (a | b);
      default: return (a & b) ^ ((idx == 5'd3) || (idx == 5'd30));
    endcase
  endfunction

  assign out20 = stub(mode, a20, b20, d20);
  assign out1  = stub(mode, a1, b1, d1);

  logic_sweep_driver #(
    .HOLD_CYCLES (20)
`ifdef SWEEP_COMPARE_EN
    ,
    .EXPECTED    (32'h8888_8888)
`endif
  ) u20 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start20),
    .a_o         (a20),
    .b_o         (b20),
    .d_o         (d20),
    .out_i       (out20),
    .busy        (busy20),
    .done        (done20),
    .table_o     (tbl20),
    .table_valid (tv20)
`ifdef SWEEP_COMPARE_EN
    ,
    .pass_o      (pass20),
    .err_cnt_o   (err20)
`endif
  );

  logic_sweep_driver #(
    .HOLD_CYCLES (1)
  ) u1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start1),
    .a_o         (a1),
    .b_o         (b1),
    .d_o         (d1),
    .out_i       (out1),
    .busy        (busy1),
    .done        (done1),
    .table_o     (tbl1),
    .table_valid (tv1)
`ifdef SWEEP_COMPARE_EN
    ,
    .pass_o      (pass1),
    .err_cnt_o   (err1)
`endif
  );

`ifndef SWEEP_COMPARE_EN
  assign err20  = '0;
  assign err1   = '0;
  assign pass20 = 1'b0;
  assign pass1  = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_done(input string tag, input exp_t e, input logic [31:0] tbl,
                            input logic tv, input logic busy, input logic [4:0] dba,
                            input logic [5:0] err, input logic pass);
    chk({tag, "_table"}, tbl, e.tbl);
    chk({tag, "_done_cycle"}, cyc, e.dcyc);
    chk({tag, "_valid_busy"}, {30'd0, tv, busy}, 32'd2);
    chk({tag, "_parked"}, {27'd0, dba}, 32'd0);
`ifdef SWEEP_COMPARE_EN
    chk({tag, "_err_cnt"}, {26'd0, err}, {26'd0, e.err});
    chk({tag, "_pass"}, {31'd0, pass}, {31'd0, e.pass});
`endif
  endtask

  // Monitors: every done pulse must consume exactly one queued expectation.
  always @(negedge clk) begin
    if (done20) begin
      if (q20.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL u20_unexpected_done: got done=1, want none (cycle %0d)", cyc);
      end else begin
        check_done("u20", q20.pop_front(), tbl20, tv20, busy20, {d20, b20, a20}, err20, pass20);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL u1_unexpected_done: got done=1, want none (cycle %0d)", cyc);
      end else begin
        check_done("u1", q1.pop_front(), tbl1, tv1, busy1, {d1, b1, a1}, err1, pass1);
      end
    end
  end

  // Called at a negedge; the accept edge is the next posedge.
  task automatic kick20(input logic push, input logic [31:0] tbl, input logic [5:0] err,
                        output int acc);
    exp_t e;
    acc = cyc + 1;
    if (push) begin
      e.tbl = tbl; e.dcyc = acc + 32 * 20; e.err = err; e.pass = (err == 6'd0);
      q20.push_back(e);
    end
    start20 = 1'b1;
    @(negedge clk);
    start20 = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int   acc;
    exp_t e;
    rst_n = 1'b0; start20 = 1'b0; start1 = 1'b0; mode = 0;
    repeat (3) @(negedge clk);

    chk("rst_drive20", {29'd0, d20, b20, a20}, 32'd0);
    chk("rst_flags20", {29'd0, busy20, done20, tv20}, 32'd0);
    chk("rst_table20", tbl20, 32'd0);
    chk("rst_flags1",  {29'd0, busy1, done1, tv1}, 32'd0);
    chk("rst_table1",  tbl1, 32'd0);
`ifdef SWEEP_COMPARE_EN
    chk("rst_cmp20", {25'd0, err20, pass20}, 32'd0);
`endif
    rst_n = 1'b1;
    wait_until(4);

    // A&B stub, start accepted at edge 5
    mode = 0;
    kick20(1'b1, 32'h8888_8888, 6'd0, acc);
    chk("t1_busy_after_accept", {31'd0, busy20}, 32'd1);
    wait_until(acc + 32 * 20 + 4);
    chk("t1_done_seen", q20.size(), 32'd0);
    chk("t1_table_held", tbl20, 32'h8888_8888);
    chk("t1_valid_held", {30'd0, tv20, busy20}, 32'd2);

    // XOR/OR stub, per-vector drive check, ignored start at vec 10
    mode = 1;
    kick20(1'b1, 32'h6E6E_6E6E, 6'd20, acc);
    chk("t2_cleared", {tbl20[30:0], tv20}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      wait_until(acc + (k + 1) * 20 - 1);
      chk("t2_vec", {27'd0, d20, b20, a20}, k);
      if (k == 10) begin
        start20 = 1'b1;
        @(negedge clk);
        start20 = 1'b0;
      end
    end
    wait_until(acc + 32 * 20 + 10);
    chk("t3_single_done", q20.size(), 32'd0);

    // Reset in the middle of vector 17
    mode = 0;
    kick20(1'b0, 32'h0, 6'd0, acc);
    wait_until(acc + 17 * 20 + 5);
    chk("t4_at_vec17", {27'd0, d20, b20, a20}, 32'd17);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_drive", {29'd0, d20, b20, a20}, 32'd0);
    chk("t4_rst_flags", {29'd0, busy20, done20, tv20}, 32'd0);
    chk("t4_rst_table", tbl20, 32'd0);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);

    // Stub with vectors 3 and 30 flipped
    mode = 2;
    kick20(1'b1, 32'hC888_8880, 6'd2, acc);
    wait_until(acc + 32 * 20 + 4);
    chk("t6_flipped_done", q20.size(), 32'd0);

    mode = 0;
    kick20(1'b1, 32'h8888_8888, 6'd0, acc);
    wait_until(acc + 32 * 20 + 4);
    chk("t4_full_resweep", q20.size(), 32'd0);

    // HOLD_CYCLES=1 with start held high: re-accepts two edges after done
    mode = 1;
    acc = cyc + 1;
    e.tbl = 32'h6E6E_6E6E; e.err = 6'd20; e.pass = 1'b0;
    e.dcyc = acc + 32;
    q1.push_back(e);
    e.dcyc = acc + 34 + 32;
    q1.push_back(e);
    start1 = 1'b1;
    wait_until(acc + 40);
    start1 = 1'b0;
    wait_until(acc + 80);
    chk("t5_retrigger_dones", q1.size(), 32'd0);
    chk("t5_idle_after", {30'd0, busy1, tv1}, 32'd1);

    chk("final_q20_empty", q20.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
